// File: rtl/spi_master_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_sequencer
// Description : Host-side wrapper around spi_master. Buffers outgoing words
//               in a TX FIFO, launches one SPI frame per word through the
//               master's valid/ready handshake, captures each received word
//               into an RX FIFO and enforces an idle gap between frames.
//               Optional frame watchdog: define SPI_SEQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_sequencer #(
   parameter int p_data_width = 24,
   parameter int p_data_count = 24,
   parameter int p_fifo_depth = 8,
   parameter int pw_fifo_addr = 3,
   parameter int p_gap_cycles = 4,
   parameter int p_timeout    = 4096
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [p_data_width-1:0] ip_tx_data,
   input  logic                    i_tx_valid,
   output logic                    o_tx_ready,
   output logic [p_data_width-1:0] op_rx_data,
   output logic                    o_rx_valid,
   input  logic                    i_rx_ready,
   output logic [p_data_width-1:0] op_spi_data,
   output logic [4:0]              op_spi_data_count,
   output logic                    o_spi_data_valid,
   input  logic [p_data_width-1:0] ip_spi_data,
   input  logic                    i_spi_ready,
   output logic                    o_busy,
   output logic                    o_rx_overflow,
   output logic                    o_timeout
);

   localparam logic [pw_fifo_addr:0]   c_fifo_full = (pw_fifo_addr+1)'(p_fifo_depth);
   localparam logic [pw_fifo_addr:0]   c_cnt_one   = (pw_fifo_addr+1)'(1);
   localparam logic [pw_fifo_addr-1:0] c_ptr_one   = pw_fifo_addr'(1);
   localparam int                      c_gap_w     = (p_gap_cycles > 0) ? $clog2(p_gap_cycles + 1) : 1;
   localparam logic [c_gap_w-1:0]      c_gap_load  = c_gap_w'(p_gap_cycles);
   localparam logic [c_gap_w-1:0]      c_gap_one   = c_gap_w'(1);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_LAUNCH     = 3'd1,
      ST_WAIT_START = 3'd2,
      ST_WAIT_DONE  = 3'd3,
      ST_CAPTURE    = 3'd4
   } state_t;

   state_t                    r_state;
   state_t                    w_next;
   logic                      r_spi_valid;
   logic [p_data_width-1:0]   r_spi_data;
   logic [c_gap_w-1:0]        r_gap;
   logic                      r_overflow;
   logic                      w_abort;

   // TX FIFO state
   logic [p_data_width-1:0]   r_tx_mem [p_fifo_depth];
   logic [pw_fifo_addr-1:0]   r_tx_wr_ptr;
   logic [pw_fifo_addr-1:0]   r_tx_rd_ptr;
   logic [pw_fifo_addr:0]     r_tx_count;
   logic                      w_tx_push;
   logic                      w_tx_pop;
   logic                      w_tx_empty;

   // RX FIFO state
   logic [p_data_width-1:0]   r_rx_mem [p_fifo_depth];
   logic [pw_fifo_addr-1:0]   r_rx_wr_ptr;
   logic [pw_fifo_addr-1:0]   r_rx_rd_ptr;
   logic [pw_fifo_addr:0]     r_rx_count;
   logic                      w_rx_push;
   logic                      w_rx_pop;
   logic                      w_rx_full;
   logic                      w_capture;

   // Ready is judged on the pre-pop count, so a push is refused when full
   // even in the cycle a launch frees a slot.
   assign o_tx_ready = (r_tx_count != c_fifo_full);
   assign w_tx_empty = (r_tx_count == '0);
   assign w_tx_push  = i_tx_valid & o_tx_ready;
   assign w_tx_pop   = (r_state == ST_LAUNCH);

   assign o_rx_valid = (r_rx_count != '0);
   assign op_rx_data = r_rx_mem[r_rx_rd_ptr];
   assign w_rx_full  = (r_rx_count == c_fifo_full);
   assign w_rx_pop   = i_rx_ready & o_rx_valid;
   assign w_capture  = (r_state == ST_CAPTURE);
   // A full RX FIFO still accepts the word when the host pops in the same cycle.
   assign w_rx_push  = w_capture & (~w_rx_full | w_rx_pop);

   assign op_spi_data       = r_spi_data;
   assign o_spi_data_valid  = r_spi_valid;
   assign op_spi_data_count = 5'(p_data_count);
   assign o_busy            = (r_state != ST_IDLE) | ~w_tx_empty;
   assign o_rx_overflow     = r_overflow;

   // TX storage write (no reset needed on data).
   always_ff @(posedge clk) begin
      if (w_tx_push) r_tx_mem[r_tx_wr_ptr] <= ip_tx_data;
   end

   // TX pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tx_wr_ptr <= '0;
         r_tx_rd_ptr <= '0;
         r_tx_count  <= '0;
      end else begin
         if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + c_ptr_one;
         if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + c_ptr_one;
         if (w_tx_push && !w_tx_pop)      r_tx_count <= r_tx_count + c_cnt_one;
         else if (!w_tx_push && w_tx_pop) r_tx_count <= r_tx_count - c_cnt_one;
      end
   end

   // RX storage write (no reset needed on data).
   always_ff @(posedge clk) begin
      if (w_rx_push) r_rx_mem[r_rx_wr_ptr] <= ip_spi_data;
   end

   // RX pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_wr_ptr <= '0;
         r_rx_rd_ptr <= '0;
         r_rx_count  <= '0;
      end else begin
         if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + c_ptr_one;
         if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + c_ptr_one;
         if (w_rx_push && !w_rx_pop)      r_rx_count <= r_rx_count + c_cnt_one;
         else if (!w_rx_push && w_rx_pop) r_rx_count <= r_rx_count - c_cnt_one;
      end
   end

   // Sticky flag for a received word that found the RX FIFO full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                  r_overflow <= 1'b0;
      else if (w_capture && w_rx_full && !w_rx_pop) r_overflow <= 1'b1;
   end

   // Next-state logic for the frame sequencer.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:       if (!w_tx_empty && i_spi_ready && (r_gap == '0)) w_next = ST_LAUNCH;
         ST_LAUNCH:     w_next = ST_WAIT_START;
         ST_WAIT_START: if (!i_spi_ready) w_next = ST_WAIT_DONE;
         ST_WAIT_DONE:  if (i_spi_ready)  w_next = ST_CAPTURE;
         ST_CAPTURE:    w_next = ST_IDLE;
         default:       w_next = ST_IDLE;
      endcase
      if (w_abort) w_next = ST_IDLE;
   end

   // State register, registered launch strobe/data, and inter-frame gap counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_spi_valid <= 1'b0;
         r_spi_data  <= '0;
         r_gap       <= '0;
      end else begin
         r_state     <= w_next;
         r_spi_valid <= (w_next == ST_LAUNCH);
         if (w_next == ST_LAUNCH) r_spi_data <= r_tx_mem[r_tx_rd_ptr];
         if (w_capture || w_abort)
            r_gap <= c_gap_load;
         else if ((r_state == ST_IDLE) && (r_gap != '0))
            r_gap <= r_gap - c_gap_one;
      end
   end

`ifdef SPI_SEQ_TIMEOUT_EN
   localparam int                 c_wd_w    = $clog2(p_timeout + 1);
   localparam logic [c_wd_w-1:0]  c_wd_last = c_wd_w'(p_timeout - 1);
   localparam logic [c_wd_w-1:0]  c_wd_one  = c_wd_w'(1);

   logic [c_wd_w-1:0] r_wd;
   logic              r_timeout;
   logic              w_waiting;

   assign w_waiting = (r_state == ST_WAIT_START) || (r_state == ST_WAIT_DONE);
   // Abort on the last allowed waiting cycle; the frame is discarded.
   assign w_abort   = w_waiting && (r_wd == c_wd_last);
   assign o_timeout = r_timeout;

   // Watchdog over the time spent waiting on the master, plus sticky flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wd      <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (w_waiting && !w_abort) r_wd <= r_wd + c_wd_one;
         else                       r_wd <= '0;
         if (w_abort) r_timeout <= 1'b1;
      end
   end
`else
   assign w_abort   = 1'b0;
   // Watchdog compiled out; the comparison folds to a constant 0.
   assign o_timeout = (p_timeout < 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_master_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master_sequencer
// Description : Self-checking bench for spi_master_sequencer with a
//               behavioural spi_master responder and TX/RX scoreboards.
//               Timeout test active when SPI_SEQ_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_sequencer;

   localparam int DW         = 24;
   localparam int GAP        = 4;
   localparam int TMO        = 64;
   localparam int SLAVE_BUSY = 3;
   localparam int BUDGET     = 2000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] ip_tx_data = '0;
   logic          i_tx_valid = 1'b0;
   logic          o_tx_ready;
   logic [DW-1:0] op_rx_data;
   logic          o_rx_valid;
   logic          i_rx_ready = 1'b0;
   logic [DW-1:0] op_spi_data;
   logic [4:0]    op_spi_data_count;
   logic          o_spi_data_valid;
   logic [DW-1:0] ip_spi_data = '0;
   logic          i_spi_ready = 1'b1;
   logic          o_busy;
   logic          o_rx_overflow;
   logic          o_timeout;

   spi_master_sequencer #(
      .p_data_width(DW), .p_data_count(24), .p_fifo_depth(8),
      .pw_fifo_addr(3), .p_gap_cycles(GAP), .p_timeout(TMO)
   ) dut (
      .clk(clk), .rst(rst),
      .ip_tx_data(ip_tx_data), .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready),
      .op_rx_data(op_rx_data), .o_rx_valid(o_rx_valid), .i_rx_ready(i_rx_ready),
      .op_spi_data(op_spi_data), .op_spi_data_count(op_spi_data_count),
      .o_spi_data_valid(o_spi_data_valid), .ip_spi_data(ip_spi_data),
      .i_spi_ready(i_spi_ready), .o_busy(o_busy),
      .o_rx_overflow(o_rx_overflow), .o_timeout(o_timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] tx;
      logic [DW-1:0] resp;
   } vec_t;

   int            checks = 0;
   int            errors = 0;
   int            frames = 0;
   int            cyc    = 0;
   logic [DW-1:0] exp_tx[$];
   logic [DW-1:0] exp_rx[$];
   logic [DW-1:0] slave_resp[$];
   bit            slave_hold  = 1'b0;
   bit            slave_stuck = 1'b0;
   bit            gap_chk     = 1'b0;
   bit            rx_auto     = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Behavioural spi_master: drops ready the cycle after a launch, holds it
   // low for SLAVE_BUSY cycles, then returns its response word with ready.
   initial begin
      int            st = 0;
      int            busy_cnt = 0;
      int            ready_edge = -1;
      logic [DW-1:0] resp;
      forever begin
         @(posedge clk); #1;
         cyc++;
         if (!gap_chk) ready_edge = -1;
         if (rst) begin
            st = 0;
            i_spi_ready = 1'b1;
         end else begin
            case (st)
               0: begin
                  i_spi_ready = !slave_hold;
                  if (o_spi_data_valid) begin
                     frames++;
                     if (exp_tx.size() == 0) check("unexpected_frame", 32'd1, 32'd0);
                     else                    check("spi_tx_word", op_spi_data, exp_tx.pop_front());
                     check("spi_data_count", op_spi_data_count, 32'd24);
                     if (gap_chk && ready_edge >= 0)
                        check("frame_gap", cyc - ready_edge, GAP + 2);
                     if (slave_stuck) st = 2;
                     else begin
                        i_spi_ready = 1'b0;
                        busy_cnt    = SLAVE_BUSY;
                        st          = 1;
                     end
                  end
               end
               1: begin
                  busy_cnt--;
                  if (busy_cnt == 0) begin
                     resp = (slave_resp.size() != 0) ? slave_resp.pop_front() : DW'($urandom);
                     ip_spi_data = resp;
                     exp_rx.push_back(resp);
                     i_spi_ready = 1'b1;
                     ready_edge  = cyc + 1;
                     st          = 0;
                  end
               end
               default: if (!slave_stuck) st = 0;
            endcase
         end
      end
   end

   // One clock step; with rx_auto set, the visible RX head is checked and popped.
   task automatic step();
      if (rx_auto && o_rx_valid) begin
         if (exp_rx.size() == 0) check("unexpected_rx", 32'd1, 32'd0);
         else                    check("rx_word", op_rx_data, exp_rx.pop_front());
         i_rx_ready = 1'b1;
      end else begin
         i_rx_ready = 1'b0;
      end
      @(posedge clk); #1;
   endtask

   task automatic push(input logic [DW-1:0] word, output bit accepted);
      ip_tx_data = word;
      i_tx_valid = 1'b1;
      accepted   = o_tx_ready;
      if (accepted) exp_tx.push_back(word);
      step();
      i_tx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (!(exp_tx.size() == 0 && !o_busy && i_spi_ready &&
               (!rx_auto || (exp_rx.size() == 0 && !o_rx_valid))) && n < BUDGET) begin
         step();
         n++;
      end
      check(name, 32'(n < BUDGET), 32'd1);
   endtask

   initial begin
      vec_t vecs[9];
      bit   acc;
      int   base;
      int   n;

      vecs[0] = '{tx: 24'hA5C3F0, resp: 24'h123456};
      for (int i = 1; i < 9; i++) vecs[i] = '{tx: DW'($urandom), resp: DW'($urandom)};

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx_ready",   o_tx_ready,       32'd1);
      check("rst_rx_valid",   o_rx_valid,       32'd0);
      check("rst_spi_valid",  o_spi_data_valid, 32'd0);
      check("rst_spi_data",   op_spi_data,      32'd0);
      check("rst_busy",       o_busy,           32'd0);
      check("rst_overflow",   o_rx_overflow,    32'd0);
      check("rst_timeout",    o_timeout,        32'd0);
      rst = 1'b0;
      step();

      // Single word with launch latency and single-cycle strobe
      base = frames;
      slave_resp.push_back(vecs[0].resp);
      push(vecs[0].tx, acc);
      check("single_accept", acc, 32'd1);
      check("latency_early", o_spi_data_valid, 32'd0);
      step();
      check("latency_valid", o_spi_data_valid, 32'd1);
      check("launch_data",   op_spi_data, vecs[0].tx);
      step();
      check("valid_one_cycle", o_spi_data_valid, 32'd0);
      wait_idle("single_idle");
      check("single_frames", frames - base, 32'd1);
      check("single_busy",   o_busy, 32'd0);
      check("single_rx_valid", o_rx_valid, 32'd1);
      check("data_held", op_spi_data, vecs[0].tx);
      rx_auto = 1'b1;
      step();
      rx_auto = 1'b0;
      check("single_rx_empty", o_rx_valid, 32'd0);

      // Burst of 8 table vectors with draining RX and gap measurement
      base    = frames;
      gap_chk = 1'b1;
      rx_auto = 1'b1;
      for (int i = 1; i < 9; i++) begin
         slave_resp.push_back(vecs[i].resp);
         push(vecs[i].tx, acc);
         check("burst_tx_ready", acc, 32'd1);
      end
      wait_idle("burst_idle");
      check("burst_frames", frames - base, 32'd8);
      gap_chk = 1'b0;
      rx_auto = 1'b0;

      // Full TX FIFO while the master is held busy
      slave_hold = 1'b1;
      step(); step();
      base = frames;
      for (int i = 0; i < 8; i++) begin
         push(DW'($urandom), acc);
         check("full_push_accept", acc, 32'd1);
      end
      check("full_tx_ready", o_tx_ready, 32'd0);
      push(24'hDEAD01, acc);
      check("full_9th_refused", acc, 32'd0);
      check("full_busy", o_busy, 32'd1);
      check("full_no_frames", frames - base, 32'd0);
      slave_hold = 1'b0;
      rx_auto    = 1'b1;
      wait_idle("full_idle");
      check("full_frames", frames - base, 32'd8);
      rx_auto = 1'b0;

      // RX overflow: 9 frames with no RX pops
      base = frames;
      for (int i = 0; i < 8; i++) push(DW'($urandom), acc);
      wait_idle("ovf_idle8");
      check("ovf_not_yet", o_rx_overflow, 32'd0);
      push(DW'($urandom), acc);
      wait_idle("ovf_idle9");
      check("ovf_frames", frames - base, 32'd9);
      check("ovf_flag", o_rx_overflow, 32'd1);
      rx_auto = 1'b1;
      for (int i = 0; i < 8; i++) step();
      rx_auto = 1'b0;
      check("ovf_rx_depth", o_rx_valid, 32'd0);
      exp_rx.delete();

      // Reset during WAIT_DONE
      slave_resp.push_back(24'h0F0F0F);
      push(24'h5A5A5A, acc);
      n = 0;
      while (i_spi_ready && n < 50) begin step(); n++; end
      check("rmf_master_busy", 32'(n < 50), 32'd1);
      step(); step();
      #3 rst = 1'b1;
      #1;
      check("rmf_tx_ready",  o_tx_ready,       32'd1);
      check("rmf_rx_valid",  o_rx_valid,       32'd0);
      check("rmf_spi_valid", o_spi_data_valid, 32'd0);
      check("rmf_spi_data",  op_spi_data,      32'd0);
      check("rmf_busy",      o_busy,           32'd0);
      check("rmf_overflow",  o_rx_overflow,    32'd0);
      @(posedge clk); #2;
      rst = 1'b0;
      exp_tx.delete();
      exp_rx.delete();
      slave_resp.delete();
      step();
      base = frames;
      slave_resp.push_back(24'h9ABCDE);
      rx_auto = 1'b1;
      push(24'h13579B, acc);
      wait_idle("rmf_idle");
      check("rmf_frames", frames - base, 32'd1);
      rx_auto = 1'b0;

`ifdef SPI_SEQ_TIMEOUT_EN
      // Watchdog: master never drops ready after launch
      slave_stuck = 1'b1;
      push(24'h777777, acc);
      step();
      check("tmo_launch", o_spi_data_valid, 32'd1);
      n = 0;
      while (!o_timeout && n < 4 * TMO) begin step(); n++; end
      check("tmo_cycle", n, TMO + 1);
      step();
      check("tmo_no_rx", o_rx_valid, 32'd0);
      check("tmo_idle",  o_busy,     32'd0);
      slave_stuck = 1'b0;
      step();
`else
      check("no_timeout", o_timeout, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_watchdog: got stuck, expected completion");
      $fatal(1, "simulation time limit");
   end

endmodule
`default_nettype wire
